// File: rtl/pipe_alu_pkg.sv
// Shared field layout, instruction struct and function codes for the pipe_ALU
// issue stage and its FIFO.
package pipe_alu_pkg;

  localparam int REG_W   = 4;
  localparam int FUNC_W  = 4;
  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 24;

  localparam int FUNC_MSB = 23;
  localparam int FUNC_LSB = 20;
  localparam int RS1_MSB  = 19;
  localparam int RS1_LSB  = 16;
  localparam int RS2_MSB  = 15;
  localparam int RS2_LSB  = 12;
  localparam int RD_MSB   = 11;
  localparam int RD_LSB   = 8;
  localparam int ADDR_MSB = 7;
  localparam int ADDR_LSB = 0;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  localparam logic [FUNC_W-1:0] ADD = 4'd0;
  localparam logic [FUNC_W-1:0] SUB = 4'd1;
  localparam logic [FUNC_W-1:0] MUL = 4'd2;
  localparam logic [FUNC_W-1:0] AND = 4'd3;
  localparam logic [FUNC_W-1:0] OR  = 4'd4;
  localparam logic [FUNC_W-1:0] XOR = 4'd5;
  localparam logic [FUNC_W-1:0] NOT = 4'd6;
  localparam logic [FUNC_W-1:0] INC = 4'd7;
  localparam logic [FUNC_W-1:0] DEC = 4'd8;
  localparam logic [FUNC_W-1:0] SLL = 4'd9;
  localparam logic [FUNC_W-1:0] SRL = 4'd10;
  localparam logic [FUNC_W-1:0] SLA = 4'd11;

  function automatic instr_t unpack_instr(input logic [INSTR_W-1:0] w);
    instr_t r;
    r.func = w[FUNC_MSB:FUNC_LSB];
    r.rs1  = w[RS1_MSB:RS1_LSB];
    r.rs2  = w[RS2_MSB:RS2_LSB];
    r.rd   = w[RD_MSB:RD_LSB];
    r.addr = w[ADDR_MSB:ADDR_LSB];
    return r;
  endfunction

  // An invalid (bubble) scoreboard slot never matches a source register.
  function automatic logic src_match(input logic v, input logic [REG_W-1:0] wr_rd,
                                     input logic [REG_W-1:0] src_a,
                                     input logic [REG_W-1:0] src_b);
    return v && ((wr_rd == src_a) || (wr_rd == src_b));
  endfunction

endpackage

// File: rtl/pipe_alu_issue_fifo.sv
// Synchronous FIFO holding packed instruction words; head word is presented
// combinationally, pushes are ignored while full even if a pop happens.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1'b1);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             full_s;
  logic             empty_s;
  logic             push_en_s;
  logic             pop_en_s;

  assign full_s    = (count_r == CNT_FULL);
  assign empty_s   = (count_r == {(PTR_W+1){1'b0}});
  assign push_en_s = push && !full_s;
  assign pop_en_s  = pop && !empty_s;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (push_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_en_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      case ({push_en_s, pop_en_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents need no reset because count_r gates visibility.
  always_ff @(posedge clk) begin
    if (push_en_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/pipe_alu_issue.sv
// Issue stage for pipe_ALU: FIFO-buffered decode with a RAW scoreboard that
// inserts bubbles until a written rd has reached the register bank.
module pipe_alu_issue
  import pipe_alu_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int HAZ_DEPTH = 3,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTR_W-1:0]     in_instr,
  output logic                   issue_valid,
  output logic [REG_W-1:0]       rs1,
  output logic [REG_W-1:0]       rs2,
  output logic [REG_W-1:0]       rd,
  output logic [FUNC_W-1:0]      func,
  output logic [ADDR_W-1:0]      addr,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam logic [CNT_W-1:0] STALL_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

  logic [INSTR_W-1:0] head_word_s;
  instr_t             head_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               hazard_s;
  logic               issue_s;
  logic [REG_W-1:0]   sb_rd_next_s;

  logic [HAZ_DEPTH-1:0]            sb_v_r;
  logic [HAZ_DEPTH-1:0][REG_W-1:0] sb_rd_r;

  logic               issue_valid_r;
  logic [REG_W-1:0]   rs1_r;
  logic [REG_W-1:0]   rs2_r;
  logic [REG_W-1:0]   rd_r;
  logic [FUNC_W-1:0]  func_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [CNT_W-1:0]   stall_cnt_r;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid),
    .pop   (issue_s),
    .wdata (in_instr),
    .rdata (head_word_s),
    .count (fifo_count),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  assign head_s = unpack_instr(head_word_s);

  // Hazard check of the FIFO head against every in-flight writer.
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < HAZ_DEPTH; i++) begin
      hazard_s = hazard_s | src_match(sb_v_r[i], sb_rd_r[i], head_s.rs1, head_s.rs2);
    end
    if (fifo_empty_s) begin
      hazard_s = 1'b0;
      issue_s  = 1'b0;
    end else begin
      issue_s  = !hazard_s;
    end
    if (issue_s) begin
      sb_rd_next_s = head_s.rd;
    end else begin
      sb_rd_next_s = rd_r;
    end
  end

  // Scoreboard shift register: one slot per issue cycle, bubbles enter as invalid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sb_v_r  <= {HAZ_DEPTH{1'b0}};
      sb_rd_r <= {(HAZ_DEPTH*REG_W){1'b0}};
    end else begin
      sb_v_r[0]  <= issue_s;
      sb_rd_r[0] <= sb_rd_next_s;
      for (int i = 1; i < HAZ_DEPTH; i++) begin
        sb_v_r[i]  <= sb_v_r[i-1];
        sb_rd_r[i] <= sb_rd_r[i-1];
      end
    end
  end

  // Output registers; fields hold through bubbles so only issue_valid marks real work.
  always_ff @(posedge clk) begin
    if (!reset) begin
      issue_valid_r <= 1'b0;
      rs1_r         <= {REG_W{1'b0}};
      rs2_r         <= {REG_W{1'b0}};
      rd_r          <= {REG_W{1'b0}};
      func_r        <= {FUNC_W{1'b0}};
      addr_r        <= {ADDR_W{1'b0}};
      stall_cnt_r   <= {CNT_W{1'b0}};
    end else begin
      issue_valid_r <= issue_s;
      if (issue_s) begin
        rs1_r  <= head_s.rs1;
        rs2_r  <= head_s.rs2;
        rd_r   <= head_s.rd;
        func_r <= head_s.func;
        addr_r <= head_s.addr;
      end
      if (hazard_s && (stall_cnt_r != STALL_MAX)) begin
        stall_cnt_r <= stall_cnt_r + STALL_ONE;
      end
    end
  end

  assign in_ready    = !fifo_full_s;
  assign issue_valid = issue_valid_r;
  assign rs1         = rs1_r;
  assign rs2         = rs2_r;
  assign rd          = rd_r;
  assign func        = func_r;
  assign addr        = addr_r;
  assign stall_cnt   = stall_cnt_r;

endmodule
